ysyx_23060191_ifu: RTL and testbench

YSYX_23060191_IFU -- requirements
Module: ysyx_23060191_ifu

---
 rtl/ysyx_23060191_ifu.sv | 73 +++++++
 tb/tb_ysyx_23060191_ifu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: PC register feeding a 2-entry {pc, inst} FIFO toward decode.
// Redirects flush the FIFO; out_* are driven only from registered FIFO state.
module ysyx_23060191_ifu #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0] imem_data,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] out_pc,
  output logic [CPU_WIDTH-1:0] out_inst
);

  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] r_fifoPc   [2];
  logic [CPU_WIDTH-1:0] r_fifoInst [2];
  logic                 r_rdPtr;
  logic                 r_wrPtr;
  logic [1:0]           r_count;

  logic                 w_deq;
  logic                 w_enq;

  assign imem_addr = r_pc;
  assign out_valid = (r_count != 2'd0);
  assign out_pc    = r_fifoPc[r_rdPtr];
  assign out_inst  = r_fifoInst[r_rdPtr];

  assign w_deq = out_valid && out_ready;
  assign w_enq = !redirect_valid && ((r_count < 2'd2) || w_deq);

  // Control state; reset wins over redirect, and a redirect discards the head even if accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[CPU_WIDTH-1:2], 2'b00};
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
    end else begin
      if (w_enq) begin
        r_pc    <= r_pc + CPU_WIDTH'(4);
        r_wrPtr <= ~r_wrPtr;
      end
      if (w_deq) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is never reset; entries are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifoPc[r_wrPtr]   <= r_pc;
      r_fifoInst[r_wrPtr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Directed self-checking bench for ysyx_23060191_ifu; the instruction memory
// returns the address XORed with a fixed key so out_inst can be predicted.
module tb_ysyx_23060191_ifu;

  localparam logic [31:0] KEY = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;

  ysyx_23060191_ifu #(.CPU_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ KEY;

  // Advance past one rising edge; all sampling and driving happens on the falling edge.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] exp;
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (imem_addr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 80000000", imem_addr); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = 32'h8000_0000 + 32'(i * 4);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL start_valid%0d: got %b expected 1", i, out_valid); end
      checks++;
      if (out_pc !== exp) begin errors++; $display("[TB] FAIL start_pc%0d: got %h expected %h", i, out_pc, exp); end
      checks++;
      if (out_inst !== (exp ^ KEY)) begin errors++; $display("[TB] FAIL start_inst%0d: got %h expected %h", i, out_inst, exp ^ KEY); end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000) begin
        errors++; $display("[TB] FAIL hold%0d: got valid=%b pc=%h expected valid=1 pc=80000000", i, out_valid, out_pc);
      end
      checks++;
      if (out_inst !== (32'h8000_0000 ^ KEY)) begin errors++; $display("[TB] FAIL hold_inst%0d: got %h expected %h", i, out_inst, 32'h8000_0000 ^ KEY); end
    end
    checks++;
    if (imem_addr !== 32'h8000_0008) begin errors++; $display("[TB] FAIL frozen_pc: got %h expected 80000008", imem_addr); end
  endtask

  task automatic test_full_deq;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0004) begin errors++; $display("[TB] FAIL drain1_pc: got valid=%b pc=%h expected valid=1 pc=80000004", out_valid, out_pc); end
    checks++;
    if (imem_addr !== 32'h8000_000C) begin errors++; $display("[TB] FAIL full_deq_addr1: got %h expected 8000000c", imem_addr); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0008) begin errors++; $display("[TB] FAIL drain2_pc: got valid=%b pc=%h expected valid=1 pc=80000008", out_valid, out_pc); end
    checks++;
    if (imem_addr !== 32'h8000_0010) begin errors++; $display("[TB] FAIL full_deq_addr2: got %h expected 80000010", imem_addr); end
  endtask

  task automatic test_redirect;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid: got %b expected 0", out_valid); end
    checks++;
    if (imem_addr !== 32'h8000_0100) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 80000100", imem_addr); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0100) begin errors++; $display("[TB] FAIL redir_pc: got valid=%b pc=%h expected valid=1 pc=80000100", out_valid, out_pc); end
    checks++;
    if (out_inst !== (32'h8000_0100 ^ KEY)) begin errors++; $display("[TB] FAIL redir_inst: got %h expected %h", out_inst, 32'h8000_0100 ^ KEY); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_redir: got valid=%b addr=%h expected valid=0 addr=fffffffc", out_valid, imem_addr); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc0: got valid=%b pc=%h expected valid=1 pc=fffffffc", out_valid, out_pc); end
    checks++;
    if (imem_addr !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap_pc1: got valid=%b pc=%h expected valid=1 pc=00000000", out_valid, out_pc); end
    checks++;
    if (out_inst !== KEY) begin errors++; $display("[TB] FAIL wrap_inst: got %h expected %h", out_inst, KEY); end
  endtask

  task automatic test_reset_priority;
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0000 || imem_addr !== 32'h0000_0008) begin
      errors++; $display("[TB] FAIL prefull: got valid=%b pc=%h addr=%h expected valid=1 pc=00000000 addr=00000008", out_valid, out_pc, imem_addr);
    end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1234_5678;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstprio_valid: got %b expected 0", out_valid); end
    checks++;
    if (imem_addr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL rstprio_addr: got %h expected 80000000", imem_addr); end
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000) begin errors++; $display("[TB] FAIL rstprio_resume: got valid=%b pc=%h expected valid=1 pc=80000000", out_valid, out_pc); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_full_deq();
    test_redirect();
    test_wrap();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
